// File: rtl/datapath_controller.sv
// ---------------------------------------------------------------------------
// datapath_controller
//   Control unit for an 8-bit accumulator datapath made of an A register, a
//   4:1 A-input mux, an add/sub unit and a 32x8 RAM. It fetches 8-bit
//   instructions from an external program ROM, decodes them, and drives the
//   datapath control lines in sequence.
//
//   Instruction: IR[7:5] opcode, IR[4:0] operand address
//     000 LOAD  001 STORE  010 ADD  011 SUB  100 INPUT  101 JZ  110 JPOS  111 HALT
//
// Ports
//   Clock       in   1       rising-edge clock
//   Reset       in   1       asynchronous active-low reset
//   Start       in   1       leaves IDLE when sampled high
//   ROMAddress  out  PC_W    program ROM address (always the PC)
//   ROMData     in   8       instruction, valid one cycle after ROMAddress
//   in_valid    in   1       input source presents a valid byte
//   in_ready    out  1       controller accepts the byte this cycle
//   Aeq0        in   1       datapath flag: A == 0
//   Apos        in   1       datapath flag: A[7] == 0
//   Asel        out  2       A mux select: 00 add/sub, 01 input, 10 RAM
//   Aload       out  1       A register load enable
//   Sub         out  1       1 = A - RAM, 0 = A + RAM
//   MemWr       out  1       RAM write enable (RAM[RAMAddress] <= A)
//   RAMAddress  out  RAM_AW  data RAM address
//   Halted      out  1       high while in HALT
// ---------------------------------------------------------------------------
module datapath_controller #(
    parameter int PC_W     = 5,
    parameter int RAM_AW   = 5,
    parameter int START_PC = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    output logic [PC_W-1:0]   ROMAddress,
    input  logic [7:0]        ROMData,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              Aeq0,
    input  logic              Apos,
    output logic [1:0]        Asel,
    output logic              Aload,
    output logic              Sub,
    output logic              MemWr,
    output logic [RAM_AW-1:0] RAMAddress,
    output logic              Halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC1  = 3'd3,
        S_EXEC2  = 3'd4,
        S_INWAIT = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_RAM = 2'b10;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;

    logic [2:0]        opcode;
    logic [RAM_AW-1:0] operand;

    assign opcode  = ir_q[7:5];
    assign operand = ir_q[RAM_AW-1:0];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_W'(START_PC);
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // The ROM is addressed straight from the PC; the registered ROM output
    // presented during DECODE is the word addressed during FETCH.
    assign ROMAddress = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        in_ready   = 1'b0;
        Asel       = ASEL_ALU;
        Aload      = 1'b0;
        Sub        = 1'b0;
        MemWr      = 1'b0;
        Halted     = 1'b0;
        RAMAddress = operand;

        case (state_q)
            S_IDLE: begin
                RAMAddress = '0;
                if (Start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                RAMAddress = '0;
                state_d    = S_DECODE;
            end

            S_DECODE: begin
                ir_d    = ROMData;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_EXEC1;
            end

            // No enables here: the RAM read of IR's operand settles so
            // EXEC2 can consume it. Jumps resolve now using the flags as
            // left by the previous instruction.
            S_EXEC1: begin
                case (opcode)
                    OP_HALT:  state_d = S_HALT;
                    OP_INPUT: state_d = S_INWAIT;
                    OP_JZ: begin
                        if (Aeq0) begin
                            pc_d = PC_W'(operand);
                        end
                        state_d = S_FETCH;
                    end
                    OP_JPOS: begin
                        if (Apos) begin
                            pc_d = PC_W'(operand);
                        end
                        state_d = S_FETCH;
                    end
                    default:  state_d = S_EXEC2;
                endcase
            end

            S_EXEC2: begin
                case (opcode)
                    OP_LOAD: begin
                        Asel  = ASEL_RAM;
                        Aload = 1'b1;
                    end
                    OP_ADD: begin
                        Asel  = ASEL_ALU;
                        Aload = 1'b1;
                    end
                    OP_SUB: begin
                        Asel  = ASEL_ALU;
                        Sub   = 1'b1;
                        Aload = 1'b1;
                    end
                    OP_STORE: begin
                        MemWr = 1'b1;
                    end
                    default: begin
                    end
                endcase
                state_d = S_FETCH;
            end

            // Aload follows in_valid combinationally so the byte is captured
            // in the same cycle the handshake completes.
            S_INWAIT: begin
                in_ready = 1'b1;
                Asel     = ASEL_IN;
                Aload    = in_valid;
                if (in_valid) begin
                    state_d = S_FETCH;
                end
            end

            S_HALT: begin
                Halted = 1'b1;
            end

            default: begin
                state_d    = S_IDLE;
                RAMAddress = '0;
            end
        endcase
    end

endmodule
